// File: rtl/job_dispatch_pkg.sv
// Shared types and parameter defaults for the job dispatcher.
// Combinational only: no latency, no flow control.
package job_dispatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam int TAG_W_DEF          = 4;
  localparam int FIFO_DEPTH_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/job_fifo.sv
// Pending-job queue: in-order, power-of-two depth, synchronous reset.
// Latency: head visible one cycle after push; backpressure: push ignored while full.
module job_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/job_dispatcher.sv
// Queues tagged jobs, launches one at a time to a worker, reports completion or timeout.
// Latency: accept->start 2 cycles, done->rsp 1 cycle; backpressure: req_ready low while queue full.
module job_dispatcher
  import job_dispatch_pkg::*;
#(
  parameter int TAG_W          = TAG_W_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             start,
  input  logic             done,
  output logic             rsp_valid,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy,
  output logic [7:0]       jobs_done,
  output logic             err_stray
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TIMER_MAX = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMER_ONE = 1;

  typedef struct packed {
    logic             timeout;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  rsp_t             rsp_q;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [TAG_W-1:0] fifo_head;
  logic             expired;

  job_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_data (req_tag),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign expired = (timer == TIMER_MAX);

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   if (done || expired) state_nxt = S_REPORT;
      S_REPORT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timer only advances below TIMER_MAX, so it can never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (state == S_ISSUE) begin
      timer <= '0;
    end else if (state == S_WAIT && !done && !expired) begin
      timer <= timer + TIMER_ONE;
    end
  end

  // A done coinciding with expiry counts as a completion, not a timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q <= '0;
    end else begin
      if (fifo_pop) rsp_q.tag <= fifo_head;
      if (state == S_WAIT) begin
        if (done)         rsp_q.timeout <= 1'b0;
        else if (expired) rsp_q.timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jobs_done <= 8'd0;
      err_stray <= 1'b0;
    end else begin
      if (state == S_REPORT && !rsp_q.timeout) jobs_done <= jobs_done + 8'd1;
      if (done && state != S_WAIT) err_stray <= 1'b1;
    end
  end

  assign req_ready   = !fifo_full;
  assign start       = (state == S_ISSUE);
  assign rsp_valid   = (state == S_REPORT);
  assign rsp_tag     = rsp_q.tag;
  assign rsp_timeout = rsp_q.timeout;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_job_dispatcher.sv
// Self-checking bench for job_dispatcher: vector table plus scoreboarded corner sequences.
module tb_job_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_tag;
  logic       req_ready;
  logic       start;
  logic       done;
  logic       rsp_valid;
  logic [3:0] rsp_tag;
  logic       rsp_timeout;
  logic       busy;
  logic [7:0] jobs_done;
  logic       err_stray;

  always #5 clk = ~clk;

  job_dispatcher #(
    .TAG_W          (4),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_tag     (req_tag),
    .req_ready   (req_ready),
    .start       (start),
    .done        (done),
    .rsp_valid   (rsp_valid),
    .rsp_tag     (rsp_tag),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .jobs_done   (jobs_done),
    .err_stray   (err_stray)
  );

  typedef struct packed {
    logic [3:0] tag;
    logic       to;
  } exp_t;

  typedef struct {
    logic [3:0] tag;
    int         done_dly;  // WAIT cycle on which done is pulsed, 0 = never
    logic       exp_to;
    int         exp_lat;   // start cycle to rsp_valid cycle
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail = 0;
  int   start_cnt = 0;
  int   rsp_cnt = 0;
  logic prev_start = 1'b0;
  int   exp_jobs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for start, optionally pulses done on WAIT cycle d, then waits for rsp_valid.
  // Returns at the negedge where rsp_valid is seen.
  task automatic run_job(input int d, output int sw, output int lat);
    logic got;
    sw  = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      sw++;
      if (start) got = 1'b1;
    end
    check("start_seen", got, 1);
    lat = 0;
    if (d > 0) begin
      repeat (d) begin
        @(negedge clk);
        lat++;
      end
      done = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      done = 1'b0;
      lat++;
      if (rsp_valid) got = 1'b1;
    end
    check("rsp_seen", got, 1);
  endtask

  // Scoreboard and start-pulse monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (start) begin
        check("start_not_consecutive", prev_start, 0);
        start_cnt++;
      end
      prev_start = start;
      if (rsp_valid) begin
        exp_t e;
        rsp_cnt++;
        if (sb.size() == 0) begin
          check("rsp_unexpected_sb_depth", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("rsp_tag", rsp_tag, e.tag);
          check("rsp_timeout", rsp_timeout, e.to);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int sw, lat, s0, r0;
    logic acc;

    vecs[0] = '{tag: 4'h5, done_dly: 8,  exp_to: 1'b0, exp_lat: 9};
    vecs[1] = '{tag: 4'hA, done_dly: 0,  exp_to: 1'b1, exp_lat: 17};
    vecs[2] = '{tag: 4'h3, done_dly: 16, exp_to: 1'b0, exp_lat: 17};
    vecs[3] = '{tag: 4'hC, done_dly: 1,  exp_to: 1'b0, exp_lat: 2};
    vecs[4] = '{tag: 4'hF, done_dly: 15, exp_to: 1'b0, exp_lat: 16};
    vecs[5] = '{tag: 4'h0, done_dly: 0,  exp_to: 1'b1, exp_lat: 17};

    // Reset with a request offered: it must not be accepted.
    reset     = 1'b1;
    req_valid = 1'b1;
    req_tag   = 4'hE;
    done      = 1'b0;
    repeat (3) @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_start", start, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_err_stray", err_stray, 0);
    repeat (4) @(negedge clk);
    check("rst_no_start", start_cnt, 0);

    // Single jobs from idle, table-driven.
    for (int i = 0; i < 6; i++) begin
      s0 = start_cnt;
      req_valid = 1'b1;
      req_tag   = vecs[i].tag;
      check($sformatf("v%0d_req_ready", i), req_ready, 1);
      sb.push_back('{tag: vecs[i].tag, to: vecs[i].exp_to});
      @(negedge clk);
      req_valid = 1'b0;
      run_job(vecs[i].done_dly, sw, lat);
      check($sformatf("v%0d_accept_to_start", i), sw + 1, 2);
      check($sformatf("v%0d_start_to_rsp", i), lat, vecs[i].exp_lat);
      if (!vecs[i].exp_to) exp_jobs++;
      @(negedge clk);
      check($sformatf("v%0d_jobs_done", i), jobs_done, exp_jobs);
      check($sformatf("v%0d_busy", i), busy, 0);
      check($sformatf("v%0d_one_start", i), start_cnt - s0, 1);
    end
    check("table_err_stray", err_stray, 0);

    // Stall a job in WAIT, then fill the queue.
    req_valid = 1'b1;
    req_tag   = 4'h7;
    sb.push_back('{tag: 4'h7, to: 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      if (start) acc = 1'b1;
    end
    check("stall_start_seen", acc, 1);
    for (int k = 1; k <= 4; k++) begin
      req_valid = 1'b1;
      req_tag   = 4'(k);
      check($sformatf("fill_ready_%0d", k), req_ready, 1);
      sb.push_back('{tag: 4'(k), to: 1'b0});
      @(negedge clk);
    end
    req_tag = 4'h5;
    check("fill_full_after_4", req_ready, 0);
    repeat (3) begin
      @(negedge clk);
      check("fill_tag5_held", req_ready, 0);
    end
    done = 1'b1;
    acc  = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      done = 1'b0;
      if (req_ready) acc = 1'b1;
    end
    check("fill_tag5_accepted", acc, 1);
    sb.push_back('{tag: 4'h5, to: 1'b0});
    check("fill_job1_issue", start, 1);
    @(negedge clk);
    req_valid = 1'b0;
    done      = 1'b1;
    @(negedge clk);
    done = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      run_job(1, sw, lat);
      check($sformatf("b2b_idle_gap_%0d", k), sw, 2);
      check($sformatf("b2b_rsp_lat_%0d", k), lat, 2);
    end
    exp_jobs += 6;
    @(negedge clk);
    check("fill_jobs_done", jobs_done, exp_jobs);
    check("fill_err_stray", err_stray, 0);

    // Stray done while idle.
    r0 = rsp_cnt;
    s0 = start_cnt;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("stray_set", err_stray, 1);
    check("stray_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("stray_sticky", err_stray, 1);
    check("stray_no_rsp", rsp_cnt - r0, 0);
    check("stray_no_start", start_cnt - s0, 0);

    // Reset mid-WAIT with two jobs queued.
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_tag   = 4'(8 + k);
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midjob_busy", busy, 1);
    r0 = rsp_cnt;
    s0 = start_cnt;
    reset     = 1'b1;
    req_valid = 1'b1;
    req_tag   = 4'hD;
    repeat (2) @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    check("rst2_req_ready", req_ready, 1);
    check("rst2_busy", busy, 0);
    check("rst2_start", start, 0);
    check("rst2_jobs_done", jobs_done, 0);
    check("rst2_err_stray", err_stray, 0);
    repeat (20) @(negedge clk);
    check("rst2_no_rsp", rsp_cnt - r0, 0);
    check("rst2_fifo_empty", start_cnt - s0, 0);
    check("rst2_idle", busy, 0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/job_dispatcher.md
JOB_DISPATCHER -- requirements
Module: job_dispatcher

Interface
REQ-001 Parameter TAG_W, default 4: width of job tag.
REQ-002 Parameter FIFO_DEPTH, default 4: pending-job queue depth, power of two >= 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum WAIT cycles before declaring timeout, >= 2.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  job request offered.
REQ-007 req_tag  input  TAG_W  tag of offered job.
REQ-008 req_ready  output  1  queue can accept; request accepted on edge where req_valid && req_ready.
REQ-009 start  output  1  one-cycle launch pulse to worker.
REQ-010 done  input  1  one-cycle completion pulse from worker.
REQ-011 rsp_valid  output  1  one-cycle completion report, no backpressure.
REQ-012 rsp_tag  output  TAG_W  tag of reported job; valid only with rsp_valid.
REQ-013 rsp_timeout  output  1  report is a timeout, not a completion; valid only with rsp_valid.
REQ-014 busy  output  1  FSM not in IDLE.
REQ-015 jobs_done  output  8  count of non-timeout completions, wraps 255 -> 0.
REQ-016 err_stray  output  1  sticky: done seen outside WAIT.

Function
REQ-017 Accepted requests SHALL enter a FIFO_DEPTH-entry FIFO in order; req_ready = FIFO not full.
REQ-018 Push and pop in same cycle SHALL both occur; occupancy unchanged; tag order preserved.
REQ-019 FSM states: IDLE, ISSUE, WAIT, REPORT; all outputs registered or decoded from registered state only.
REQ-020 IDLE: if FIFO non-empty, pop head into tag register, go ISSUE; else stay.
REQ-021 ISSUE: start = 1 for exactly this one cycle; WAIT timer cleared to 0; go WAIT.
REQ-022 WAIT: done = 1 -> go REPORT, timeout flag 0; else timer == TIMEOUT_CYCLES-1 -> go REPORT, timeout flag 1; else timer +1.
REQ-023 done and timer expiry in same cycle: done wins, timeout flag 0.
REQ-024 REPORT: rsp_valid = 1 one cycle with rsp_tag and rsp_timeout; jobs_done +1 if not timeout; go IDLE.
REQ-025 Latency, idle and empty FIFO: request accepted at edge N -> start high in cycle after edge N+1; done sampled at edge M -> rsp_valid high in cycle after edge M.
REQ-026 Back-to-back jobs: minimum 4 cycles between start pulses (ISSUE, WAIT >= 1, REPORT, IDLE).
REQ-027 done in IDLE, ISSUE or REPORT SHALL be ignored for FSM purposes and SHALL set err_stray.
REQ-028 start SHALL never be asserted in two consecutive cycles.
REQ-029 Timer width = clog2(TIMEOUT_CYCLES); it SHALL never wrap.

Reset
REQ-030 On reset: state IDLE, FIFO empty, timer 0, start 0, rsp_valid 0, rsp_tag 0, rsp_timeout 0, busy 0, jobs_done 0, err_stray 0.
REQ-031 Reset mid-job SHALL abandon the job with no report; req_ready = 1 in the first cycle after reset deasserts.
REQ-032 req_valid during reset SHALL not be accepted.

Structure
REQ-033 Package job_dispatch_pkg SHALL hold the state enum (2-bit) and parameter defaults.
REQ-034 FIFO SHALL be a sub-module job_fifo (push/pop/full/empty/data, sync reset); the FSM, timer and counters stay in job_dispatcher.

Verification
REQ-035 Single job tag 0x5, done 8 cycles after start -> one start pulse, rsp_valid once, rsp_tag 0x5, rsp_timeout 0, jobs_done 1.
REQ-036 Done never returned, tag 0xA -> rsp_valid exactly 16 cycles after WAIT entry, rsp_timeout 1, jobs_done unchanged.
REQ-037 Push tags 1,2,3,4,5 back-to-back with FSM stalled -> req_ready low after 4th accept; tag 5 held; responses in order 1..5.
REQ-038 done on the 16th WAIT cycle, coinciding with expiry -> rsp_timeout 0, jobs_done +1.
REQ-039 done pulse in IDLE -> err_stray 1 and held; no rsp_valid; cleared only by reset.
REQ-040 reset during WAIT with 2 queued -> no rsp_valid, busy 0, FIFO empty, jobs_done 0, start low.
